pupil_locator: RTL and testbench

- Stream consumer that sits downstream of the RGB-to-grayscale select stage in the pupil-search pipeline.
- Each frame, it reads the grayscale pixel stream and its H/V counters, keeps the pixels darker than a threshold inside a search window, and accumulates their count and X/Y coordinate sums.
- At frame end it runs a sequential divider to produce the dark-region centroid, oX/oY.
- The marker-drawing stage uses oX/oY to place its box.

---
 rtl/pupil_locator.sv | 160 ++++++++++++++++
 tb/tb_pupil_locator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pupil_locator.sv
// Dark-region centroid finder: accumulates dark pixels inside a search window each frame,
// then divides the coordinate sums by the count with a bit-serial restoring divider.
module pupil_locator #(
    parameter int WIN_X0    = 0,
    parameter int WIN_X1    = 1280,
    parameter int WIN_Y0    = 0,
    parameter int WIN_Y1    = 1024,
    parameter int MIN_COUNT = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [9:0]  iGray,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic [9:0]  iThreshold,
    output logic [12:0] oX,
    output logic [12:0] oY,
    output logic        oFound,
    output logic        oValid,
    output logic        oBusy,
    output logic        oDrop
);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

    state_t      state;
    logic        fvalReg;
    logic [9:0]  thr;
    logic [20:0] cnt;
    logic [31:0] sx;
    logic [31:0] sy;

    logic [20:0] divCnt;
    logic [31:0] divSy;
    logic [31:0] quo;
    logic [20:0] rem;
    logic [4:0]  iter;
    logic [12:0] qx;

    int          hPos;
    int          vPos;
    int          cntLatched;
    logic        inWin;
    logic        qualify;
    logic        frameEnd;
    logic        cntSat;
    logic        foundNow;

    logic [21:0] remShift;
    logic        remGe;
    logic [20:0] remSub;
    logic [20:0] remNext;

    assign hPos       = {19'd0, iH_Cont};
    assign vPos       = {19'd0, iV_Cont};
    assign inWin      = (hPos >= WIN_X0) && (hPos < WIN_X1) && (vPos >= WIN_Y0) && (vPos < WIN_Y1);
    assign qualify    = iFVAL && iDVAL && (iGray < thr) && inWin;
    assign frameEnd   = fvalReg && !iFVAL;
    assign cntSat     = &cnt;
    assign cntLatched = {11'd0, divCnt};
    assign foundNow   = (divCnt != 21'd0) && (cntLatched >= MIN_COUNT);

    // One restoring step: the dividend shifts out of quo's MSB while quotient bits enter its LSB.
    assign remShift = {rem, quo[31]};
    assign remGe    = remShift >= {1'b0, divCnt};
    assign remSub   = remShift[20:0] - divCnt;
    assign remNext  = remGe ? remSub : remShift[20:0];

    // Accumulation never waits on the divider; a frame end always starts a fresh frame.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fvalReg <= 1'b0;
            thr     <= 10'h3FF;
            cnt     <= 21'd0;
            sx      <= 32'd0;
            sy      <= 32'd0;
        end else begin
            fvalReg <= iFVAL;
            if (frameEnd) begin
                cnt <= 21'd0;
                sx  <= 32'd0;
                sy  <= 32'd0;
                thr <= iThreshold;
            end else if (qualify && !cntSat) begin
                cnt <= cnt + 21'd1;
                sx  <= sx + {19'd0, iH_Cont};
                sy  <= sy + {19'd0, iV_Cont};
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            divCnt <= 21'd0;
            divSy  <= 32'd0;
            quo    <= 32'd0;
            rem    <= 21'd0;
            iter   <= 5'd0;
            qx     <= 13'd0;
            oX     <= 13'd0;
            oY     <= 13'd0;
            oFound <= 1'b0;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            oDrop  <= 1'b0;
        end else begin
            oValid <= 1'b0;
            oDrop  <= frameEnd && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frameEnd) begin
                        divCnt <= cnt;
                        quo    <= sx;
                        divSy  <= sy;
                        rem    <= 21'd0;
                        iter   <= 5'd0;
                        oBusy  <= 1'b1;
                        state  <= DIV_X;
                    end
                end
                DIV_X: begin
                    quo  <= {quo[30:0], remGe};
                    rem  <= remNext;
                    iter <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        qx    <= {quo[11:0], remGe};
                        quo   <= divSy;
                        rem   <= 21'd0;
                        state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    quo  <= {quo[30:0], remGe};
                    rem  <= remNext;
                    iter <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (foundNow) begin
                        oX     <= qx;
                        oY     <= quo[12:0];
                        oFound <= 1'b1;
                    end else begin
                        oFound <= 1'b0;
                    end
                    oValid <= 1'b1;
                    oBusy  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pupil_locator.sv
// Directed bench for pupil_locator: three instances (MIN_COUNT=16, MIN_COUNT=64,
// and MIN_COUNT=16 with WIN_X0=200) share one stimulus stream.
module tb_pupil_locator;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFVAL;
    logic        iDVAL;
    logic [9:0]  iGray;
    logic [12:0] iH_Cont;
    logic [12:0] iV_Cont;
    logic [9:0]  iThreshold;

    logic [12:0] oX[3];
    logic [12:0] oY[3];
    logic        oFound[3];
    logic        oValid[3];
    logic        oBusy[3];
    logic        oDrop[3];

    int          checks = 0;
    int          passed = 0;
    int          cycle = 0;
    int          e0Cycle = 0;
    int          vCount[3];
    int          vCycle[3];
    logic [12:0] vX[3];
    logic [12:0] vY[3];
    logic        vFound[3];
    int          dropCount = 0;
    int          dropCycle = 0;

    always #5 iCLK = ~iCLK;

    pupil_locator #(.MIN_COUNT(16)) u_main (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iGray(iGray),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .iThreshold(iThreshold),
        .oX(oX[0]), .oY(oY[0]), .oFound(oFound[0]), .oValid(oValid[0]),
        .oBusy(oBusy[0]), .oDrop(oDrop[0])
    );

    pupil_locator #(.MIN_COUNT(64)) u_min64 (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iGray(iGray),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .iThreshold(iThreshold),
        .oX(oX[1]), .oY(oY[1]), .oFound(oFound[1]), .oValid(oValid[1]),
        .oBusy(oBusy[1]), .oDrop(oDrop[1])
    );

    pupil_locator #(.WIN_X0(200), .MIN_COUNT(16)) u_win (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iGray(iGray),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .iThreshold(iThreshold),
        .oX(oX[2]), .oY(oY[2]), .oFound(oFound[2]), .oValid(oValid[2]),
        .oBusy(oBusy[2]), .oDrop(oDrop[2])
    );

    // Advance one clock and sample 1ns after the edge, logging result and drop pulses.
    task automatic tick();
        @(posedge iCLK);
        #1;
        cycle++;
        for (int i = 0; i < 3; i++) begin
            if (oValid[i]) begin
                vCount[i]++;
                vCycle[i] = cycle;
                vX[i]     = oX[i];
                vY[i]     = oY[i];
                vFound[i] = oFound[i];
            end
        end
        if (oDrop[0]) begin
            dropCount++;
            dropCycle = cycle;
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) begin
            vCount[i] = 0;
            vCycle[i] = 0;
        end
        dropCount = 0;
    endtask

    // Raster over a region; pixels inside the block get gIn, the rest gOut. Ends on edge E0.
    task automatic send_frame(input int x0, input int y0, input int w, input int h,
                              input int bx0, input int by0, input int bw, input int bh,
                              input logic [9:0] gIn, input logic [9:0] gOut);
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                iFVAL   = 1'b1;
                iDVAL   = 1'b1;
                iH_Cont = 13'(x);
                iV_Cont = 13'(y);
                iGray   = (x >= bx0 && x < bx0 + bw && y >= by0 && y < by0 + bh) ? gIn : gOut;
                tick();
            end
        end
        iFVAL = 1'b0;
        iDVAL = 1'b0;
        tick();
        e0Cycle = cycle;
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 100 && vCount[0] == 0; n++) tick();
    endtask

    task automatic test_reset();
        iRST = 1'b1; iFVAL = 1'b1; iDVAL = 1'b1; iGray = 10'd1023;
        iH_Cont = 13'd5; iV_Cont = 13'd5; iThreshold = 10'd100;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({oX[i], oY[i], oFound[i], oValid[i], oBusy[i], oDrop[i]} !== 30'd0)
                $display("FAIL reset_outputs[%0d]: got %h want 0", i,
                         {oX[i], oY[i], oFound[i], oValid[i], oBusy[i], oDrop[i]});
            else passed++;
        end
        iRST = 1'b0;
        clear_obs();
        send_frame(0, 0, 8, 4, 0, 0, 0, 0, 10'd0, 10'd1023);
        checks++;
        if (oBusy[0] !== 1'b1) $display("FAIL busy_after_e0: got %b want 1", oBusy[0]); else passed++;
        wait_valid();
        checks++;
        if (vCount[0] !== 1) $display("FAIL reset_valid_count: got %0d want 1", vCount[0]); else passed++;
        checks++;
        if (vCycle[0] - e0Cycle !== 65) $display("FAIL reset_valid_latency: got %0d want 65", vCycle[0] - e0Cycle); else passed++;
        checks++;
        if ({vFound[0], vX[0], vY[0]} !== 27'd0)
            $display("FAIL reset_empty_result: got found=%b x=%0d y=%0d want 0/0/0", vFound[0], vX[0], vY[0]);
        else passed++;
        checks++;
        if (oBusy[0] !== 1'b0) $display("FAIL busy_after_done: got %b want 0", oBusy[0]); else passed++;
    endtask

    task automatic test_dark_block();
        clear_obs();
        send_frame(96, 196, 12, 12, 100, 200, 4, 4, 10'd10, 10'd900);
        wait_valid();
        repeat (3) tick();
        checks++;
        if (vCount[0] !== 1) $display("FAIL block_valid_pulses: got %0d want 1", vCount[0]); else passed++;
        checks++;
        if (vCycle[0] - e0Cycle !== 65) $display("FAIL block_latency: got %0d want 65", vCycle[0] - e0Cycle); else passed++;
        checks++;
        if ({vFound[0], vX[0], vY[0]} !== {1'b1, 13'd101, 13'd201})
            $display("FAIL block_centroid: got found=%b x=%0d y=%0d want 1/101/201", vFound[0], vX[0], vY[0]);
        else passed++;
        checks++;
        if ({vCount[1] == 1, vFound[1], vX[1], vY[1]} !== {1'b1, 1'b0, 13'd0, 13'd0})
            $display("FAIL block_min64: got n=%0d found=%b x=%0d y=%0d want 1/0/0/0", vCount[1], vFound[1], vX[1], vY[1]);
        else passed++;
        checks++;
        if ({vFound[2], vX[2]} !== {1'b0, 13'd0})
            $display("FAIL block_outside_window: got found=%b x=%0d want 0/0", vFound[2], vX[2]);
        else passed++;
    endtask

    task automatic test_threshold_equal();
        clear_obs();
        send_frame(196, 300, 16, 4, 196, 300, 16, 4, 10'd100, 10'd900);
        wait_valid();
        checks++;
        if ({vCount[0] == 1, vFound[0], vX[0], vY[0]} !== {1'b1, 1'b0, 13'd101, 13'd201})
            $display("FAIL equal_threshold: got n=%0d found=%b x=%0d y=%0d want 1/0/101/201", vCount[0], vFound[0], vX[0], vY[0]);
        else passed++;
        checks++;
        if (vFound[2] !== 1'b0) $display("FAIL equal_threshold_win: got %b want 0", vFound[2]); else passed++;
    endtask

    task automatic test_window_edge();
        clear_obs();
        send_frame(196, 300, 8, 4, 196, 300, 8, 4, 10'd10, 10'd900);
        wait_valid();
        checks++;
        if ({vFound[2], vX[2], vY[2]} !== {1'b1, 13'd201, 13'd301})
            $display("FAIL window_edge_win: got found=%b x=%0d y=%0d want 1/201/301", vFound[2], vX[2], vY[2]);
        else passed++;
        checks++;
        if ({vFound[0], vX[0], vY[0]} !== {1'b1, 13'd199, 13'd301})
            $display("FAIL window_edge_main: got found=%b x=%0d y=%0d want 1/199/301", vFound[0], vX[0], vY[0]);
        else passed++;
        checks++;
        if ({vFound[1], vX[1]} !== {1'b0, 13'd0})
            $display("FAIL window_edge_min64: got found=%b x=%0d want 0/0", vFound[1], vX[1]);
        else passed++;
    endtask

    task automatic test_drop();
        clear_obs();
        send_frame(96, 196, 12, 12, 100, 200, 4, 4, 10'd10, 10'd900);
        for (int n = 1; n <= 70; n++) begin
            if (n < 20) begin
                iFVAL = 1'b1; iDVAL = 1'b1; iGray = 10'd10;
                iH_Cont = 13'(500 + n); iV_Cont = 13'd600;
            end else begin
                iFVAL = 1'b0; iDVAL = 1'b0;
            end
            tick();
        end
        checks++;
        if (dropCount !== 1) $display("FAIL drop_pulses: got %0d want 1", dropCount); else passed++;
        checks++;
        if (dropCycle - e0Cycle !== 20) $display("FAIL drop_timing: got %0d want 20", dropCycle - e0Cycle); else passed++;
        checks++;
        if ({vCount[0] == 1, vCycle[0] - e0Cycle == 65} !== 2'b11)
            $display("FAIL drop_first_valid: got n=%0d at %0d want 1 at 65", vCount[0], vCycle[0] - e0Cycle);
        else passed++;
        checks++;
        if ({vFound[0], vX[0], vY[0]} !== {1'b1, 13'd101, 13'd201})
            $display("FAIL drop_first_result: got found=%b x=%0d y=%0d want 1/101/201", vFound[0], vX[0], vY[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int          e0a;
        int          firstCycle;
        int          firstCount;
        logic [12:0] firstX;
        logic [12:0] firstY;
        logic        firstFound;
        clear_obs();
        send_frame(296, 396, 9, 9, 298, 398, 5, 5, 10'd10, 10'd900);
        e0a = e0Cycle;
        send_frame(306, 401, 9, 9, 308, 403, 5, 5, 10'd10, 10'd900);
        firstCount = vCount[0]; firstCycle = vCycle[0];
        firstX = vX[0]; firstY = vY[0]; firstFound = vFound[0];
        vCount[0] = 0;
        wait_valid();
        checks++;
        if ({firstCount == 1, firstCycle - e0a == 65} !== 2'b11)
            $display("FAIL b2b_first_valid: got n=%0d at %0d want 1 at 65", firstCount, firstCycle - e0a);
        else passed++;
        checks++;
        if ({firstFound, firstX, firstY} !== {1'b1, 13'd300, 13'd400})
            $display("FAIL b2b_first_result: got found=%b x=%0d y=%0d want 1/300/400", firstFound, firstX, firstY);
        else passed++;
        checks++;
        if ({vCount[0] == 1, vCycle[0] - e0Cycle == 65} !== 2'b11)
            $display("FAIL b2b_second_valid: got n=%0d at %0d want 1 at 65", vCount[0], vCycle[0] - e0Cycle);
        else passed++;
        checks++;
        if ({vFound[0], vX[0], vY[0]} !== {1'b1, 13'd310, 13'd405})
            $display("FAIL b2b_second_result: got found=%b x=%0d y=%0d want 1/310/405", vFound[0], vX[0], vY[0]);
        else passed++;
        checks++;
        if (dropCount !== 0) $display("FAIL b2b_no_drop: got %0d want 0", dropCount); else passed++;
    endtask

    task automatic test_reset_abort();
        clear_obs();
        send_frame(296, 396, 9, 9, 298, 398, 5, 5, 10'd10, 10'd900);
        repeat (10) tick();
        checks++;
        if (oBusy[0] !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", oBusy[0]); else passed++;
        #2;
        iRST = 1'b1;
        #1;
        checks++;
        if ({oX[0], oY[0], oFound[0], oValid[0], oBusy[0], oDrop[0]} !== 30'd0)
            $display("FAIL abort_outputs: got x=%0d y=%0d found=%b busy=%b want all 0", oX[0], oY[0], oFound[0], oBusy[0]);
        else passed++;
        tick();
        iRST = 1'b0;
        repeat (80) tick();
        checks++;
        if (vCount[0] !== 0) $display("FAIL abort_no_valid: got %0d want 0", vCount[0]); else passed++;
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_dark_block();
        test_threshold_equal();
        test_window_edge();
        test_drop();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
